// File: rtl/clic_core_pkg.sv
// Shared types for the core-side CLIC interrupt responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clic_core_pkg;

    // Handshake progress: waiting for an offer, trap raised to the
    // pipeline, and the single ready-pulse cycle after commit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        READY = 2'd2
    } state_e;

    // Privilege encodings as carried on irq_mode_i / priv_i.
    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

endpackage

// File: rtl/clic_irq_qualify.sv
// Decides whether an offered CLIC interrupt may preempt the hart right now.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from current inputs.
//
// Ports:
//   irq_level_i/irq_mode_i : offered interrupt level and target privilege
//   priv_i, mie_i, sie_i   : current hart privilege and global enables
//   mil_i, thresh_i        : active interrupt level and level threshold
//   qualify_o              : offer is allowed to trap
module clic_irq_qualify
    import clic_core_pkg::*;
#(
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned ModeWidth = 2
) (
    input  logic [PrioWidth-1:0] irq_level_i,
    input  logic [ModeWidth-1:0] irq_mode_i,
    input  logic [ModeWidth-1:0] priv_i,
    input  logic                 mie_i,
    input  logic                 sie_i,
    input  logic [PrioWidth-1:0] mil_i,
    input  logic [PrioWidth-1:0] thresh_i,
    output logic                 qualify_o
);

    logic                 mode_en;
    logic                 mode_is_m;
    logic [PrioWidth-1:0] level_floor;

    always_comb begin
        mode_is_m = (irq_mode_i == ModeWidth'(PRIV_M));

        // Global enable belonging to the interrupt's target mode; the
        // reserved encoding has no enable and never qualifies.
        mode_en = 1'b0;
        if (mode_is_m) begin
            mode_en = mie_i;
        end else if (irq_mode_i == ModeWidth'(PRIV_S)) begin
            mode_en = sie_i;
        end

        // Same-mode preemption must beat both the running level and the threshold.
        level_floor = (mil_i > thresh_i) ? mil_i : thresh_i;

        qualify_o = 1'b0;
        if (irq_mode_i > priv_i) begin
            // A higher-privilege target always preempts into M; S still
            // needs its own enable.
            qualify_o = mode_is_m || mode_en;
        end else if (irq_mode_i == priv_i) begin
            qualify_o = mode_en && (irq_level_i > level_floor);
        end
    end

endmodule

// File: rtl/clic_core_irq_if.sv
// Core-side responder for the CLIC valid/ready + kill_req/kill_ack handshake.
// Latency: offer captured in 1 cycle, trap_req next; ready pulses 1 cycle after trap_ack.
// Backpressure: offers ignored while a trap is pending or completing; kill granted only before commit.
//
// Ports:
//   irq_*_i / irq_ready_o / irq_kill_*  : CLIC-side handshake
//   priv_i, mie_i, sie_i[, thresh_i]    : hart state used to qualify the offer
//   trap_*_o / trap_ack_i               : trap request to the pipeline and its commit
//   mret_i, mpil_i, mil_o               : active interrupt level tracking
// Build option: CLIC_INTTHRESH_EN adds thresh_i to the same-mode level compare.
module clic_core_irq_if
    import clic_core_pkg::*;
#(
    parameter int unsigned SrcWidth  = 8,
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned ModeWidth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 irq_valid_i,
    output logic                 irq_ready_o,
    input  logic [SrcWidth-1:0]  irq_id_i,
    input  logic [PrioWidth-1:0] irq_level_i,
    input  logic [ModeWidth-1:0] irq_mode_i,
    input  logic                 irq_kill_req_i,
    output logic                 irq_kill_ack_o,
    input  logic [ModeWidth-1:0] priv_i,
    input  logic                 mie_i,
    input  logic                 sie_i,
`ifdef CLIC_INTTHRESH_EN
    input  logic [PrioWidth-1:0] thresh_i,
`endif
    output logic                 trap_req_o,
    input  logic                 trap_ack_i,
    output logic [SrcWidth-1:0]  trap_id_o,
    output logic [PrioWidth-1:0] trap_level_o,
    output logic [ModeWidth-1:0] trap_mode_o,
    input  logic                 mret_i,
    input  logic [PrioWidth-1:0] mpil_i,
    output logic [PrioWidth-1:0] mil_o
);

    state_e               state_q, state_d;
    logic [SrcWidth-1:0]  id_q;
    logic [PrioWidth-1:0] level_q;
    logic [ModeWidth-1:0] mode_q;
    logic [PrioWidth-1:0] mil_q, mil_d;
    logic [PrioWidth-1:0] thresh;
    logic                 qualify;
    logic                 capture;
    logic                 commit;

`ifdef CLIC_INTTHRESH_EN
    assign thresh = thresh_i;
`else
    assign thresh = '0;
`endif

    clic_irq_qualify #(
        .PrioWidth (PrioWidth),
        .ModeWidth (ModeWidth)
    ) u_qualify (
        .irq_level_i (irq_level_i),
        .irq_mode_i  (irq_mode_i),
        .priv_i      (priv_i),
        .mie_i       (mie_i),
        .sie_i       (sie_i),
        .mil_i       (mil_q),
        .thresh_i    (thresh),
        .qualify_o   (qualify)
    );

    always_comb begin
        state_d        = state_q;
        capture        = 1'b0;
        commit         = 1'b0;
        irq_kill_ack_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (irq_valid_i && qualify) begin
                    capture = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Once the pipeline commits, the trap is architecturally taken
                // and a simultaneous kill can no longer be honoured.
                if (trap_ack_i) begin
                    commit  = 1'b1;
                    state_d = READY;
                end else if (irq_kill_req_i) begin
                    irq_kill_ack_o = 1'b1;
                    state_d        = IDLE;
                end else if (!(irq_valid_i && qualify)) begin
                    // Source withdrawn or hart state changed: abandon silently.
                    state_d = IDLE;
                end
            end
            READY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Trap entry takes precedence over an mret retiring in the same cycle.
        mil_d = mil_q;
        if (commit) begin
            mil_d = level_q;
        end else if (mret_i) begin
            mil_d = mpil_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            level_q <= '0;
            mode_q  <= '0;
            mil_q   <= '0;
        end else begin
            state_q <= state_d;
            mil_q   <= mil_d;
            if (capture) begin
                id_q    <= irq_id_i;
                level_q <= irq_level_i;
                mode_q  <= irq_mode_i;
            end
        end
    end

    assign trap_req_o   = (state_q == REQ);
    assign irq_ready_o  = (state_q == READY);
    assign trap_id_o    = id_q;
    assign trap_level_o = level_q;
    assign trap_mode_o  = mode_q;
    assign mil_o        = mil_q;

endmodule

// File: tb/tb_clic_core_irq_if.sv
module tb_clic_core_irq_if;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       irq_valid_i;
    logic       irq_ready_o;
    logic [7:0] irq_id_i;
    logic [7:0] irq_level_i;
    logic [1:0] irq_mode_i;
    logic       irq_kill_req_i;
    logic       irq_kill_ack_o;
    logic [1:0] priv_i;
    logic       mie_i;
    logic       sie_i;
    logic [7:0] thresh_i;
    logic       trap_req_o;
    logic       trap_ack_i;
    logic [7:0] trap_id_o;
    logic [7:0] trap_level_o;
    logic [1:0] trap_mode_o;
    logic       mret_i;
    logic [7:0] mpil_i;
    logic [7:0] mil_o;

    always #5 clk_i = ~clk_i;

    clic_core_irq_if dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .irq_valid_i    (irq_valid_i),
        .irq_ready_o    (irq_ready_o),
        .irq_id_i       (irq_id_i),
        .irq_level_i    (irq_level_i),
        .irq_mode_i     (irq_mode_i),
        .irq_kill_req_i (irq_kill_req_i),
        .irq_kill_ack_o (irq_kill_ack_o),
        .priv_i         (priv_i),
        .mie_i          (mie_i),
        .sie_i          (sie_i),
`ifdef CLIC_INTTHRESH_EN
        .thresh_i       (thresh_i),
`endif
        .trap_req_o     (trap_req_o),
        .trap_ack_i     (trap_ack_i),
        .trap_id_o      (trap_id_o),
        .trap_level_o   (trap_level_o),
        .trap_mode_o    (trap_mode_o),
        .mret_i         (mret_i),
        .mpil_i         (mpil_i),
        .mil_o          (mil_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       req;
        logic       rdy;
        logic       kack;
        logic [7:0] id;
        logic [7:0] lvl;
        logic [1:0] mode;
        logic [7:0] mil;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Transaction-level reference: one outstanding trap record, a flag for
    // the ready-pulse cycle, and the active level.
    bit         m_pend;
    bit         m_rdy;
    logic [7:0] m_id, m_lvl, m_mil;
    logic [1:0] m_mode;

    function automatic void chk(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic bit eligible();
        int thr;
        int floor_lvl;
        bit en;
`ifdef CLIC_INTTHRESH_EN
        thr = int'(thresh_i);
`else
        thr = 0;
`endif
        floor_lvl = (int'(m_mil) > thr) ? int'(m_mil) : thr;
        en = (irq_mode_i == 2'd3) ? mie_i : (irq_mode_i == 2'd1) ? sie_i : 1'b0;
        if (irq_mode_i > priv_i) return (irq_mode_i == 2'd3) || en;
        if (irq_mode_i == priv_i) return en && (int'(irq_level_i) > floor_lvl);
        return 1'b0;
    endfunction

    function automatic void model_clear();
        m_pend = 0; m_rdy = 0;
        m_id = '0; m_lvl = '0; m_mode = '0; m_mil = '0;
    endfunction

    // Inputs are already applied for this cycle: record what the DUT must
    // show now, advance the model across the coming edge, then move on.
    task automatic cycle();
        exp_t e;
        bit   elig;
        e.req  = m_pend;
        e.rdy  = m_rdy;
        e.kack = m_pend && irq_kill_req_i && !trap_ack_i;
        e.id   = m_id;
        e.lvl  = m_lvl;
        e.mode = m_mode;
        e.mil  = m_mil;
        exp_q.push_back(e);
        if (rst_ni) begin
            elig = eligible();
            if (m_pend && trap_ack_i) m_mil = m_lvl;
            else if (mret_i)          m_mil = mpil_i;
            if (m_rdy) begin
                m_rdy = 0;
            end else if (m_pend) begin
                if (trap_ack_i) begin
                    m_pend = 0;
                    m_rdy  = 1;
                end else if (irq_kill_req_i || !(irq_valid_i && elig)) begin
                    m_pend = 0;
                end
            end else if (irq_valid_i && elig) begin
                m_pend = 1;
                m_id   = irq_id_i;
                m_lvl  = irq_level_i;
                m_mode = irq_mode_i;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv(input bit v, input int id, input int lvl, input int mode,
                       input bit kill = 0, input bit ack = 0,
                       input bit mret = 0, input int mpil = 0);
        irq_valid_i    = v;
        irq_id_i       = 8'(id);
        irq_level_i    = 8'(lvl);
        irq_mode_i     = 2'(mode);
        irq_kill_req_i = kill;
        trap_ack_i     = ack;
        mret_i         = mret;
        mpil_i         = 8'(mpil);
        cycle();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_clear();
        cycle();
        cycle();
        rst_ni = 1'b1;
    endtask

    always @(negedge clk_i) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("trap_req",   int'(trap_req_o),     int'(mon_e.req));
            chk("irq_ready",  int'(irq_ready_o),    int'(mon_e.rdy));
            chk("kill_ack",   int'(irq_kill_ack_o), int'(mon_e.kack));
            chk("trap_id",    int'(trap_id_o),      int'(mon_e.id));
            chk("trap_level", int'(trap_level_o),   int'(mon_e.lvl));
            chk("trap_mode",  int'(trap_mode_o),    int'(mon_e.mode));
            chk("mil",        int'(mil_o),          int'(mon_e.mil));
        end
    end

    initial begin
        int r;
        rst_ni = 1'b0;
        irq_valid_i = 0; irq_id_i = '0; irq_level_i = '0; irq_mode_i = '0;
        irq_kill_req_i = 0; trap_ack_i = 0; mret_i = 0; mpil_i = '0;
        priv_i = 2'd3; mie_i = 1; sie_i = 1; thresh_i = '0;
        @(posedge clk_i);
        #1;
        do_reset();

        // Basic M-mode trap: capture, commit, ready pulse.
        drv(1, 5, 'h40, 3);
        drv(1, 5, 'h40, 3, 0, 1);
        chk("tp1_ready", int'(irq_ready_o), 1);
        chk("tp1_mil",   int'(mil_o), 'h40);
        chk("tp1_id",    int'(trap_id_o), 5);
        drv(0, 0, 0, 0);

        // Running at level 0x80: lower same-mode level is held off.
        drv(0, 0, 0, 0, 0, 0, 1, 'h80);
        drv(1, 3, 'h40, 3);
        drv(1, 3, 'h40, 3);
        chk("tp2_noreq", int'(trap_req_o), 0);
        drv(1, 4, 'h90, 3);
        drv(1, 4, 'h90, 3, 0, 1);
        drv(0, 0, 0, 0);

        // Kill before commit, kill while idle, then a fresh capture.
        drv(1, 7, 'hA0, 3);
        drv(1, 7, 'hA0, 3, 1, 0);
        drv(0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 0);
        drv(1, 9, 'hA0, 3);
        chk("tp3_id", int'(trap_id_o), 9);
        // Kill and commit together: commit wins, mret in the same cycle loses.
        drv(1, 9, 'hA0, 3, 1, 1, 1, 'h11);
        chk("tp4_ready", int'(irq_ready_o), 1);
        chk("tp4_mil",   int'(mil_o), 'hA0);
        drv(0, 0, 0, 0);

        // Source withdrawn while requesting, then mret restores the level.
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        drv(1, 11, 'h30, 3);
        drv(0, 11, 'h30, 3);
        drv(0, 0, 0, 0, 0, 0, 1, 'h20);
        chk("tp5_mil", int'(mil_o), 'h20);

        // Higher-privilege M target ignores mie; S target from U needs sie.
        priv_i = 2'd1; mie_i = 0;
        drv(1, 12, 'h05, 3);
        drv(1, 12, 'h05, 3, 0, 1);
        drv(0, 0, 0, 0);
        priv_i = 2'd0; sie_i = 0;
        drv(1, 13, 'hFF, 1);
        drv(1, 13, 'hFF, 1);
        sie_i = 1;
        drv(1, 13, 'hFF, 1);
        drv(1, 13, 'hFF, 1, 1, 0);
        drv(0, 0, 0, 0);

        // Threshold: 0x90 only passes when no threshold is configured.
        priv_i = 2'd3; mie_i = 1;
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        thresh_i = 8'hA0;
        drv(1, 14, 'h90, 3);
        drv(0, 0, 0, 0);
        drv(1, 15, 'hB0, 3);
        drv(1, 15, 'hB0, 3, 0, 1);
        drv(0, 0, 0, 0);

        // Reset in the middle of a request.
        drv(1, 16, 'hC0, 3);
        do_reset();
        chk("rst_mil", int'(mil_o), 0);
        chk("rst_req", int'(trap_req_o), 0);
        thresh_i = '0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 2);
                priv_i = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : 2'd3;
                mie_i  = 1'($urandom_range(0, 3) != 0);
                sie_i  = 1'($urandom_range(0, 3) != 0);
                thresh_i = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            end
            r = $urandom_range(0, 9);
            drv($urandom_range(0, 9) < 7,
                int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)),
                (r < 5) ? 3 : (r < 8) ? 1 : (r < 9) ? 0 : 2,
                $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 35,
                $urandom_range(0, 99) < 6,
                int'($urandom_range(0, 127)));
        end

        drv(0, 0, 0, 0);
        @(negedge clk_i);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clic_core_irq_if.md
Name: clic_core_irq_if

Overview:
- Core-side responder for the CLIC interrupt handshake (valid/ready plus kill_req/kill_ack), the opposite end of the CLIC target arbiter.
- Qualifies each offered interrupt against the current hart privilege, global enables, active interrupt level (mil) and threshold.
- Raises a trap request to the pipeline and completes the handshake with ready once the pipeline commits the trap.
- Grants kill requests only while no trap has been committed, and tracks the active interrupt level across trap entry and mret.

Parameters:
- SrcWidth, 8, width of interrupt ID.
- PrioWidth, 8, width of interrupt level/priority.
- ModeWidth, 2, privilege mode encoding width (U=0, S=1, M=3).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- irq_valid_i  in  1  interrupt offered by CLIC.
- irq_ready_o  out  1  handshake accept; one-cycle pulse.
- irq_id_i  in  SrcWidth  offered interrupt ID.
- irq_level_i  in  PrioWidth  offered interrupt level.
- irq_mode_i  in  ModeWidth  offered interrupt privilege mode.
- irq_kill_req_i  in  1  CLIC request to abandon the handshake.
- irq_kill_ack_o  out  1  kill granted; combinational.
- priv_i  in  ModeWidth  current hart privilege.
- mie_i  in  1  mstatus.MIE.
- sie_i  in  1  mstatus.SIE.
- thresh_i  in  PrioWidth  mintthresh; present only with CLIC_INTTHRESH_EN.
- trap_req_o  out  1  interrupt trap request to pipeline.
- trap_ack_i  in  1  pipeline committed the trap this cycle.
- trap_id_o  out  SrcWidth  captured ID.
- trap_level_o  out  PrioWidth  captured level.
- trap_mode_o  out  ModeWidth  captured mode.
- mret_i  in  1  mret retiring.
- mpil_i  in  PrioWidth  mcause.MPIL restored on mret.
- mil_o  out  PrioWidth  current active interrupt level.

Behaviour:
- Reset values:
  - irq_ready_o=0, irq_kill_ack_o=0, trap_req_o=0.
  - trap_id_o/level_o/mode_o=0, mil_o=0.
  - State IDLE.
- Qualify, combinational:
  - Case 1: irq_mode_i > priv_i, and the enable for irq_mode_i is on (M uses mie_i, S uses sie_i). Enable is ignored when irq_mode_i > priv_i and the target is M.
  - Case 2: irq_mode_i == priv_i, the enable for that mode is on, and irq_level_i > max(mil_q, thresh).
  - Unsigned comparisons. thresh=0 when the macro is absent.
- State IDLE:
  - If irq_valid_i && qualify: capture id/level/mode into registers, then go to REQ next cycle. Capture latency 1 cycle.
- State REQ: trap_req_o=1 from the registered state. Priority order:
  - 1. trap_ack_i=1: set mil_q <= captured level, go to READY. kill_req_i in the same cycle is NOT acked; trap wins.
  - 2. irq_kill_req_i=1: irq_kill_ack_o=1 this cycle, go to IDLE, trap_req_o drops next cycle.
  - 3. !irq_valid_i or !qualify (level-triggered source cleared, or CSR change): go to IDLE. No ack and no ready.
- State READY:
  - irq_ready_o=1 for exactly one cycle, then IDLE.
  - irq_kill_ack_o is never asserted in READY.
- irq_kill_ack_o=0 in IDLE and READY. A kill_req seen in IDLE is ignored.
- mret_i: mil_q <= mpil_i.
  - If mret_i and trap_ack_i coincide, trap_ack_i wins.
- New offers are not sampled during REQ/READY.
- Captured fields hold until the next capture.
- Reset mid-operation returns to IDLE with all outputs at reset values. The CLIC side recovers via its level-clear/kill path.

Optional Feature:
- Macro CLIC_INTTHRESH_EN.
- Defined: thresh_i port exists and participates in the same-mode level comparison.
- Undefined: no thresh_i port; threshold is constant 0.

Decomposition:
- Package clic_core_pkg: state enum (IDLE, REQ, READY) and privilege constants PRIV_U/PRIV_S/PRIV_M.
- Sub-module clic_irq_qualify: combinational qualify function (priv/enable/level/threshold compare), reused by future S-mode CLIC variants.

Test Plan:
- priv=M, mie=1, mil=0: offer id=5, level=0x40, mode=M → trap_req 1 cycle later. trap_ack → ready pulse next cycle, mil_o=0x40, trap_id_o=5.
- mil=0x80: same-mode offer level=0x40 → no trap_req, ready stays 0. Level 0x90 → accepted.
- In REQ: kill_req, no trap_ack → kill_ack=1 same cycle, trap_req=0 next cycle, no ready. Re-offer id=9 → new capture of id 9.
- In REQ: kill_req and trap_ack in the same cycle → no kill_ack, ready pulse next cycle, mil updated.
- In REQ: irq_valid_i drops → back to IDLE, no ready, no kill_ack. mret with mpil=0x20 → mil_o=0x20.
- With CLIC_INTTHRESH_EN, thresh=0xA0, mil=0: level 0x90 rejected, 0xB0 accepted. Without the macro, 0x90 is accepted.
